// File: rtl/pcs_40g_pkg.sv
// Shared 40GBASE-R PCS constants: lane geometry, sync headers, per-lane marker octets.
package pcs_40g_pkg;
  localparam int LANE_N         = 4;
  localparam int BLOCK_W        = 64;
  localparam int HEAD_W         = 2;
  localparam int AM_GAP_DEFAULT = 16383;

  localparam logic [HEAD_W-1:0] SYNC_CTRL = 2'b01;

  // AM_LANE[lane][m] is marker octet Mm of that lane
  localparam logic [LANE_N-1:0][2:0][7:0] AM_LANE = '{
    '{8'h3D, 8'h79, 8'hA2},
    '{8'h9B, 8'h65, 8'hC5},
    '{8'hE6, 8'hC4, 8'hF0},
    '{8'h47, 8'h76, 8'h90}
  };

  typedef enum logic {S_AM = 1'b0, S_DATA = 1'b1} am_state_t;

  function automatic logic [BLOCK_W-1:0] am_payload(input logic [2:0][7:0] m,
                                                    input logic [7:0]      bip3,
                                                    input logic [7:0]      bip7);
    return {bip7, ~m[2], ~m[1], ~m[0], bip3, m[2], m[1], m[0]};
  endfunction
endpackage

// File: rtl/am_bip_calc.sv
// BIP3 contribution of one 66b block: bit i is the parity of data bits i, i+8, ...,
// with the two sync-header bits folded into bits 3 and 4.
module am_bip_calc
  import pcs_40g_pkg::*;
(
  input  logic [HEAD_W-1:0]  head,
  input  logic [BLOCK_W-1:0] data,
  output logic [7:0]         bip
);
  always_comb begin
    bip = 8'h00;
    for (int j = 0; j < BLOCK_W / 8; j++) bip = bip ^ data[j*8 +: 8];
    bip[3] = bip[3] ^ head[0];
    bip[4] = bip[4] ^ head[1];
  end
endmodule

// File: rtl/am_insert_40g_tx.sv
// 40GBASE-R per-lane alignment marker inserter (TX). Optional BIP error injection
// on lane 0 is enabled by defining AM_INSERT_BIP_ERR_INJ_EN.
module am_insert_40g_tx
  import pcs_40g_pkg::*;
#(
  parameter int AM_GAP = AM_GAP_DEFAULT,
  parameter int CNT_W  = (AM_GAP > 1) ? $clog2(AM_GAP) : 1
) (
  input  logic                      clk,
  input  logic                      nreset,
  input  logic                      valid_i,
  input  logic [LANE_N*HEAD_W-1:0]  head_i,
  input  logic [LANE_N*BLOCK_W-1:0] data_i,
`ifdef AM_INSERT_BIP_ERR_INJ_EN
  input  logic                      err_inj_i,
`endif
  output logic                      ready_o,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [LANE_N*HEAD_W-1:0]  head_o,
  output logic [LANE_N*BLOCK_W-1:0] data_o
);
  am_state_t                      state, state_nxt;
  logic [CNT_W-1:0]               cnt, cnt_nxt;
  logic [LANE_N-1:0][7:0]         acc, acc_nxt;
  logic                           valid_nxt;
  logic [LANE_N*HEAD_W-1:0]       head_nxt;
  logic [LANE_N*BLOCK_W-1:0]      data_nxt;
  logic                           load, inj;
  logic [LANE_N-1:0][7:0]         data_bip, am_bip;
  logic [LANE_N-1:0][BLOCK_W-1:0] am_word;

  assign load    = ready_i | ~valid_o;
  assign ready_o = (state == S_DATA) & load;

`ifdef AM_INSERT_BIP_ERR_INJ_EN
  logic inj_flag;
  assign inj = inj_flag;

  // A pulse on the marker-load cycle arms the following marker instead
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset)                      inj_flag <= 1'b0;
    else if (load && state == S_AM)   inj_flag <= err_inj_i;
    else if (err_inj_i)               inj_flag <= 1'b1;
  end
`else
  assign inj = 1'b0;
`endif

  for (genvar l = 0; l < LANE_N; l++) begin : g_lane
    logic [7:0] bip3;
    // BIP7 always carries the true complement, so a corrupted BIP3 is detectable
    assign bip3       = acc[l] ^ {7'd0, inj & (l == 0)};
    assign am_word[l] = am_payload(AM_LANE[l], bip3, ~acc[l]);

    am_bip_calc u_data_bip (
      .head (head_i[l*HEAD_W +: HEAD_W]),
      .data (data_i[l*BLOCK_W +: BLOCK_W]),
      .bip  (data_bip[l])
    );

    am_bip_calc u_am_bip (
      .head (SYNC_CTRL),
      .data (am_word[l]),
      .bip  (am_bip[l])
    );
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    valid_nxt = valid_o;
    head_nxt  = head_o;
    data_nxt  = data_o;
    if (load) begin
      case (state)
        S_AM: begin
          valid_nxt = 1'b1;
          head_nxt  = {LANE_N{SYNC_CTRL}};
          data_nxt  = am_word;
          acc_nxt   = am_bip;
          state_nxt = S_DATA;
        end
        default: begin
          if (valid_i) begin
            valid_nxt = 1'b1;
            head_nxt  = head_i;
            data_nxt  = data_i;
            acc_nxt   = acc ^ data_bip;
            if (cnt == CNT_W'(AM_GAP - 1)) begin
              cnt_nxt   = '0;
              state_nxt = S_AM;
            end else begin
              cnt_nxt = cnt + 1'b1;
            end
          end else begin
            valid_nxt = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state   <= S_AM;
      cnt     <= '0;
      acc     <= '0;
      valid_o <= 1'b0;
      head_o  <= '0;
      data_o  <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      acc     <= acc_nxt;
      valid_o <= valid_nxt;
      head_o  <= head_nxt;
      data_o  <= data_nxt;
    end
  end
endmodule
